// File: rtl/ud_counter_lim_pkg.sv
// Shared definitions for the limited up/down counter: limit-handling mode
// constants, the per-cycle operation selector, and the full-adder cell the
// ripple add/subtract chain is built from.
package ud_counter_lim_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Which register update wins this cycle (Reset is handled asynchronously).
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_COUNT
  } op_e;

  // Single-bit full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/ud_counter_lim_addsub_rca.sv
// Width-bit ripple-carry adder/subtractor. Subtraction is A + ~B + 1.
// o_cb is the carry-out when adding and the borrow when subtracting, so in
// both directions a 1 means the true result left the 0..2^W-1 range.
module ud_counter_lim_addsub_rca
  import ud_counter_lim_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_result,
  output logic         o_cb
);

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    logic       v_c;
    logic [1:0] v_fa;
    o_result = '0;
    v_c      = i_sub;
    for (int unsigned i = 0; i < W; i++) begin
      v_fa        = full_add(i_a[i], i_b[i] ^ i_sub, v_c);
      o_result[i] = v_fa[0];
      v_c         = v_fa[1];
    end
    // A subtract with no borrow produces carry-out 1, hence the inversion.
    o_cb = i_sub ? ~v_c : v_c;
  end

endmodule

// File: rtl/ud_counter_lim.sv
// Parametrised up/down counter with programmable step, min/max limits,
// wrap or saturate behaviour at the limits, clamped parallel load,
// registered terminal flags and sticky overflow/underflow status.
// All outputs come straight from registers.
module ud_counter_lim
  import ud_counter_lim_pkg::*;
#(
  parameter int width      = 8,
  parameter int step_width = 4,
  parameter int val_preset = 0,
  parameter int sat_mode   = MODE_WRAP
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CountEn,
  input  logic                  SClear,
  input  logic                  DownEn,
  input  logic                  Load,
  input  logic [width-1:0]      LoadVal,
  input  logic [step_width-1:0] Step,
  input  logic [width-1:0]      LimitMin,
  input  logic [width-1:0]      LimitMax,
  input  logic                  OvfClear,
  output logic [width-1:0]      Count,
  output logic                  AtMax,
  output logic                  AtMin,
  output logic                  TermPulse,
  output logic                  Ovf,
  output logic                  Unf
);

  localparam bit              SAT    = (sat_mode == MODE_SAT);
  localparam logic [width-1:0] PRESET = width'(val_preset);

  logic [width-1:0] r_count;
  logic             r_atmax;
  logic             r_atmin;
  logic             r_term;
  logic             r_ovf;
  logic             r_unf;

  logic [width-1:0] w_step_ext;
  logic [width-1:0] w_res;
  logic             w_cb;
  logic             w_limits_ok;
  logic             w_over;
  logic             w_under;
  logic [width-1:0] w_load_val;
  op_e              w_op;
  logic [width-1:0] w_next_count;
  logic             w_cross_up;
  logic             w_cross_dn;

  assign w_step_ext = width'(Step);

  ud_counter_lim_addsub_rca #(
    .W(width)
  ) u_addsub (
    .i_a     (r_count),
    .i_b     (w_step_ext),
    .i_sub   (DownEn),
    .o_result(w_res),
    .o_cb    (w_cb)
  );

  // Limit checks on the add/sub result; the carry/borrow flags a 2^width
  // wrap, which always counts as leaving the window.
  always_comb begin
    w_limits_ok = (LimitMin <= LimitMax);
    w_over      = w_cb | (w_res > LimitMax);
    w_under     = w_cb | (w_res < LimitMin);
  end

  // Load value: clamped into the window only when the window is valid.
  always_comb begin
    w_load_val = LoadVal;
    if (w_limits_ok) begin
      if (LoadVal < LimitMin) begin
        w_load_val = LimitMin;
      end else if (LoadVal > LimitMax) begin
        w_load_val = LimitMax;
      end
    end
  end

  // Select this cycle's operation by priority: SClear > Load > CountEn.
  // A zero step or an inverted window turns CountEn into a plain hold.
  always_comb begin
    w_op = OP_HOLD;
    if (SClear) begin
      w_op = OP_CLEAR;
    end else if (Load) begin
      w_op = OP_LOAD;
    end else if (CountEn && w_limits_ok && (Step != '0)) begin
      w_op = OP_COUNT;
    end
  end

  // Next count value and crossing detection.
  always_comb begin
    w_next_count = r_count;
    w_cross_up   = 1'b0;
    w_cross_dn   = 1'b0;
    unique case (w_op)
      OP_CLEAR: w_next_count = PRESET;
      OP_LOAD:  w_next_count = w_load_val;
      OP_COUNT: begin
        if (!DownEn) begin
          if (w_over) begin
            w_cross_up   = 1'b1;
            w_next_count = SAT ? LimitMax : LimitMin;
          end else begin
            w_next_count = w_res;
          end
        end else begin
          if (w_under) begin
            w_cross_dn   = 1'b1;
            w_next_count = SAT ? LimitMin : LimitMax;
          end else begin
            w_next_count = w_res;
          end
        end
      end
      default: w_next_count = r_count;
    endcase
  end

  // Count, equality flags, terminal pulse and sticky status registers.
  // Sticky flags: a new crossing in the same cycle as OvfClear wins.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= PRESET;
      r_atmax <= 1'b0;
      r_atmin <= 1'b0;
      r_term  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_atmax <= (w_next_count == LimitMax);
      r_atmin <= (w_next_count == LimitMin);
      r_term  <= w_cross_up | w_cross_dn;
      r_ovf   <= w_cross_up | (r_ovf & ~OvfClear);
      r_unf   <= w_cross_dn | (r_unf & ~OvfClear);
    end
  end

  assign Count     = r_count;
  assign AtMax     = r_atmax;
  assign AtMin     = r_atmin;
  assign TermPulse = r_term;
  assign Ovf       = r_ovf;
  assign Unf       = r_unf;

endmodule

// File: tb/tb_ud_counter_lim.sv
// Scoreboard bench for ud_counter_lim. Three instances share one stimulus:
// 8-bit wrap, 8-bit saturate and 9-bit wrap, all with preset 4. The driver
// advances an integer reference model after every clock edge and queues the
// expected outputs; a monitor pops and compares on each sample strobe.
module tb_ud_counter_lim;

  localparam int PRESET = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CountEn, SClear, DownEn, Load, OvfClear;
  logic [8:0] LoadVal, LimitMin, LimitMax;
  logic [3:0] Step;

  logic [7:0] c0, c1;
  logic [8:0] c2;
  logic       amax0, amin0, term0, ovf0, unf0;
  logic       amax1, amin1, term1, ovf1, unf1;
  logic       amax2, amin2, term2, ovf2, unf2;

  always #5 Clock = ~Clock;

  ud_counter_lim #(.width(8), .step_width(4), .val_preset(PRESET), .sat_mode(0)) u0 (
    .Clock(Clock), .Reset(Reset), .CountEn(CountEn), .SClear(SClear), .DownEn(DownEn),
    .Load(Load), .LoadVal(LoadVal[7:0]), .Step(Step), .LimitMin(LimitMin[7:0]),
    .LimitMax(LimitMax[7:0]), .OvfClear(OvfClear), .Count(c0), .AtMax(amax0),
    .AtMin(amin0), .TermPulse(term0), .Ovf(ovf0), .Unf(unf0));

  ud_counter_lim #(.width(8), .step_width(4), .val_preset(PRESET), .sat_mode(1)) u1 (
    .Clock(Clock), .Reset(Reset), .CountEn(CountEn), .SClear(SClear), .DownEn(DownEn),
    .Load(Load), .LoadVal(LoadVal[7:0]), .Step(Step), .LimitMin(LimitMin[7:0]),
    .LimitMax(LimitMax[7:0]), .OvfClear(OvfClear), .Count(c1), .AtMax(amax1),
    .AtMin(amin1), .TermPulse(term1), .Ovf(ovf1), .Unf(unf1));

  ud_counter_lim #(.width(9), .step_width(4), .val_preset(PRESET), .sat_mode(0)) u2 (
    .Clock(Clock), .Reset(Reset), .CountEn(CountEn), .SClear(SClear), .DownEn(DownEn),
    .Load(Load), .LoadVal(LoadVal), .Step(Step), .LimitMin(LimitMin),
    .LimitMax(LimitMax), .OvfClear(OvfClear), .Count(c2), .AtMax(amax2),
    .AtMin(amin2), .TermPulse(term2), .Ovf(ovf2), .Unf(unf2));

  logic [8:0] a_cnt [3];
  logic [4:0] a_flg [3];
  assign a_cnt[0] = {1'b0, c0};
  assign a_cnt[1] = {1'b0, c1};
  assign a_cnt[2] = c2;
  assign a_flg[0] = {amax0, amin0, term0, ovf0, unf0};
  assign a_flg[1] = {amax1, amin1, term1, ovf1, unf1};
  assign a_flg[2] = {amax2, amin2, term2, ovf2, unf2};

  // Reference model state: plain integers and bits.
  typedef struct {
    int cnt;
    bit amax, amin, term, ovf, unf;
  } mstate_t;

  typedef struct packed {
    logic [1:0] dut;
    logic [8:0] cnt;
    logic [4:0] flg;
  } exp_t;

  mstate_t ms [3];
  int      cfg_w   [3] = '{8, 8, 9};
  bit      cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
  exp_t    q [$];
  exp_t    e;
  int      n_vec = 0;
  int      n_bad = 0;
  event    sample_ev;

  function automatic mstate_t m_reset();
    mstate_t r;
    r.cnt = PRESET; r.amax = 0; r.amin = 0; r.term = 0; r.ovf = 0; r.unf = 0;
    return r;
  endfunction

  // One clock edge of the counter, from the behavioural rules.
  function automatic mstate_t m_step(mstate_t s, int w, bit sat);
    mstate_t n;
    int mask, lv, mn, mx, st, t;
    bit up_x, dn_x;
    if (Reset) return m_reset();
    mask = (1 << w) - 1;
    lv = int'(LoadVal) & mask;
    mn = int'(LimitMin) & mask;
    mx = int'(LimitMax) & mask;
    st = int'(Step);
    n = s;
    up_x = 0;
    dn_x = 0;
    if (SClear) begin
      n.cnt = PRESET;
    end else if (Load) begin
      if (mn <= mx) n.cnt = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
      else n.cnt = lv;
    end else if (CountEn && mn <= mx && st != 0) begin
      if (!DownEn) begin
        t = s.cnt + st;
        if (t > mx) begin
          up_x = 1;
          n.cnt = sat ? mx : mn;
        end else n.cnt = t;
      end else begin
        t = s.cnt - st;
        if (t < mn) begin
          dn_x = 1;
          n.cnt = sat ? mn : mx;
        end else n.cnt = t;
      end
    end
    n.term = up_x | dn_x;
    n.ovf  = up_x | (s.ovf & !OvfClear);
    n.unf  = dn_x | (s.unf & !OvfClear);
    n.amax = (n.cnt == mx);
    n.amin = (n.cnt == mn);
    return n;
  endfunction

  task automatic push_all();
    exp_t x;
    for (int d = 0; d < 3; d++) begin
      x.dut = 2'(d);
      x.cnt = 9'(ms[d].cnt);
      x.flg = {ms[d].amax, ms[d].amin, ms[d].term, ms[d].ovf, ms[d].unf};
      q.push_back(x);
    end
  endtask

  // Advance one clock edge: step the model with the inputs sampled there.
  task automatic tick();
    @(posedge Clock);
    #1;
    for (int d = 0; d < 3; d++) ms[d] = m_step(ms[d], cfg_w[d], cfg_sat[d]);
    push_all();
  endtask

  task automatic idle();
    SClear = 0; Load = 0; CountEn = 0; OvfClear = 0;
  endtask

  // Called just after tick(): assert Reset between edges, check that the
  // outputs have already returned to reset values, release before the edge.
  task automatic async_rst();
    #5;
    Reset = 1;
    #1;
    for (int d = 0; d < 3; d++) ms[d] = m_reset();
    push_all();
    -> sample_ev;
    #1;
    Reset = 0;
  endtask

  always @(negedge Clock) -> sample_ev;

  // Monitor: compare every queued expectation at the sample strobe.
  always begin
    @(sample_ev);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (a_cnt[e.dut] !== e.cnt || a_flg[e.dut] !== e.flg) begin
        n_bad++;
        $display("FAIL dut%0d t=%0t: Count=%0d {AtMax,AtMin,Term,Ovf,Unf}=%b, expected Count=%0d flags=%b",
                 e.dut, $time, a_cnt[e.dut], a_flg[e.dut], e.cnt, e.flg);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; idle(); DownEn = 0; Step = 0; LoadVal = 0;
    LimitMin = 0; LimitMax = 255;
    #1;
    for (int d = 0; d < 3; d++) ms[d] = m_reset();
    push_all();
    tick();
    Reset = 0;
    tick();

    // Wrap up-count 10..20 step 3 from 18.
    LimitMin = 10; LimitMax = 20; Step = 3; LoadVal = 18; Load = 1;
    tick();
    idle(); CountEn = 1;
    repeat (6) tick();

    // Down-count below 0 from 2 with step 5.
    idle(); LimitMin = 0; LimitMax = 255; LoadVal = 2; Load = 1;
    tick();
    idle(); CountEn = 1; DownEn = 1; Step = 5;
    repeat (3) tick();

    // Priority: SClear over Load over CountEn, then clamped load.
    DownEn = 0; SClear = 1; Load = 1; CountEn = 1; LoadVal = 300;
    tick();
    SClear = 0; LimitMax = 200;
    tick();
    idle();
    tick();

    // Carry-out boundary 254 + 15 with full 8-bit window.
    LimitMax = 255; LoadVal = 254; Load = 1;
    tick();
    idle(); CountEn = 1; Step = 15;
    tick();
    idle();
    tick();

    // Sticky clear alone, then clear concurrent with a new overflow.
    OvfClear = 1;
    tick();
    idle(); LoadVal = 254; Load = 1;
    tick();
    idle(); CountEn = 1; OvfClear = 1;
    tick();
    idle();
    tick();

    // Inverted window: counting ignored, load unclamped.
    LimitMin = 50; LimitMax = 20; CountEn = 1; Step = 7;
    repeat (2) tick();
    idle(); LoadVal = 100; Load = 1;
    tick();

    // Count outside a valid window, then zero step.
    idle(); LimitMin = 10; LimitMax = 60; CountEn = 1; Step = 1;
    tick();
    Step = 0; DownEn = 1;
    repeat (2) tick();

    // Asynchronous reset while Count = 7, then resume.
    idle(); LimitMin = 0; LimitMax = 255; LoadVal = 7; Load = 1;
    tick();
    idle(); CountEn = 1; DownEn = 0; Step = 1;
    async_rst();
    repeat (3) tick();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      if (i % 40 == 0) begin
        r = $urandom_range(0, 9);
        if (r < 2) begin
          LimitMin = 0; LimitMax = 511;
        end else if (r < 4) begin
          LimitMin = 9'($urandom_range(100, 255)); LimitMax = 9'($urandom_range(0, 99));
        end else begin
          LimitMin = 9'($urandom_range(0, 200));
          LimitMax = LimitMin + 9'($urandom_range(0, 55));
        end
      end
      r = $urandom_range(0, 99);
      SClear   = (r < 3);
      Load     = (r >= 3 && r < 10);
      CountEn  = ($urandom_range(0, 9) < 8);
      DownEn   = 1'($urandom_range(0, 1));
      Step     = 4'($urandom_range(0, 15));
      OvfClear = ($urandom_range(0, 9) == 0);
      LoadVal  = 9'($urandom_range(0, 511));
      tick();
      if (i % 97 == 50) async_rst();
    end

    idle();
    tick();
    repeat (2) @(negedge Clock);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
